mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences and shares one unified memory port between the instruction-fetch stage and the load/store (MEM) stage of the 5-stage RV32I pipeline. It grants one requester at a time, and drives a single-outstanding request/accept/response handshake toward memory. It returns read data and a one-cycle completion pulse to the owning stage, and produces per-stage stall signals for the control unit. Data accesses have priority, and a starvation counter guarantees forward progress for fetch.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_MAX`, 4, consecutive fetch arbitration losses before fetch is forced to win (1..15)

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high
- `if_req`  in  1  fetch request; held with `if_addr` stable until `if_done`
- `if_addr`  in  ADDR_W  fetch address (word access, read only)
- `if_rdata`  out  DATA_W  fetched instruction, valid when `if_done`=1, held otherwise
- `if_done`  out  1  one-cycle completion pulse for fetch
- `d_req`  in  1  data request; held with attributes stable until `d_done`
- `d_we`  in  1  1=store, 0=load
- `d_size`  in  3  access size code, passed through unchanged
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_rdata`  out  DATA_W  load data, valid when `d_done`=1, held otherwise
- `d_done`  out  1  one-cycle completion pulse for data
- `stall_if`  out  1  `if_req & ~if_done` (combinational)
- `stall_mem`  out  1  `d_req & ~d_done` (combinational)
- `m_req`  out  1  memory request valid
- `m_we`, `m_size`, `m_addr`, `m_wdata`  out  1/3/ADDR_W/DATA_W  latched attributes of the granted transaction
- `m_ready`  in  1  memory accepts the request this cycle (`m_req & m_ready`)
- `m_rvalid`  in  1  response/ack for the accepted transaction (reads and writes)
- `m_rdata`  in  DATA_W  read data, valid with `m_rvalid`

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP; 1-bit `owner` (0=fetch, 1=data); starvation counter `starve_cnt` (4 bits).
- IDLE transitions:
  - No request: stay in IDLE.
  - A request is present: grant it, latch its attributes into the `m_*` registers, and go to ISSUE.
  - Fetch grant attributes: `m_we`=0, `m_size`=3'b010, `m_wdata`=0.
- Arbitration in IDLE when both requests are present:
  - Data wins unless `starve_cnt`==`STARVE_MAX`; in that case fetch wins.
  - `starve_cnt` increments (saturating at `STARVE_MAX`) each time fetch loses while `if_req`=1.
  - `starve_cnt` clears to 0 on every fetch grant.
- ISSUE: `m_req`=1. On `m_ready`=1 go to WAIT; otherwise stay, with the `m_*` outputs held constant.
- WAIT: `m_req`=0. On `m_rvalid`=1:
  - Capture `m_rdata` into `if_rdata` or `d_rdata`, according to `owner`.
  - Go to RESP.
- RESP: assert the owner's `done` for exactly this cycle, then go to IDLE.
  - The owner must drop its request, or present a new one, in the following cycle.
- `m_rvalid` outside WAIT is ignored. `m_rdata` is captured for stores too, but is don't-care for them.
- Requests are latched, so a requester that deasserts `req` mid-transaction is a protocol violation. The transaction still completes and `done` still pulses.
- Reset values:
  - state=IDLE, `owner`=0, `starve_cnt`=0.
  - `m_req`=0, `m_we`=0, `m_size`=0, `m_addr`=0, `m_wdata`=0.
  - `if_done`=`d_done`=0, `if_rdata`=`d_rdata`=0.
- Reset mid-operation: the FSM returns immediately to IDLE and any in-flight memory response is ignored. Requesters re-issue after reset deasserts.

## Timing
- Cycle 0: request seen in IDLE, grant registered.
- Cycle 1: `m_req`=1 (ISSUE).
- Minimum latency (`m_ready` in cycle 1, `m_rvalid` in cycle 2):
  - `done` in cycle 3.
  - New grant at the earliest in cycle 4; port occupancy is 4 cycles per access.
- Each ISSUE cycle without `m_ready` adds 1 cycle. Each WAIT cycle without `m_rvalid` adds 1 cycle.
- `done` and `rdata` are registered and update together on the RESP entry edge. `rdata` is held until the next completion for the same owner.
- A new request appearing during ISSUE/WAIT/RESP is not granted until IDLE. `stall_*` covers that wait.

## Test plan
- Single fetch:
  - Stimulus: `if_addr`=0x100; memory gives `m_ready` in cycle 1 and `m_rvalid` in cycle 2 with 0x00500093.
  - Required: `m_req` high only in cycle 1 with `m_addr`=0x100, `m_we`=0; `if_done`=1 in cycle 3 with `if_rdata`=0x00500093; `stall_if`=1 in cycles 0–2.
- Simultaneous requests:
  - Stimulus: fetch 0x104 and store 0x200 (`d_wdata`=0xDEADBEEF, `d_size`=2) both in cycle 0.
  - Required: store issued first (`m_we`=1, `m_addr`=0x200); `d_done` in cycle 3; fetch granted in cycle 4; `if_done` in cycle 7.
- Starvation, with `STARVE_MAX`=4:
  - Stimulus: `if_req` and `d_req` held high continuously, with `d_req` re-presented after every `d_done`.
  - Required: exactly 4 data completions, then 1 fetch completion; pattern repeats.
- Backpressure:
  - Stimulus: `m_ready` held low for 3 cycles; `m_rvalid` delayed 5 cycles after accept.
  - Required: `m_*` stable throughout ISSUE; `done` exactly once, 1 cycle after `m_rvalid`.
- Spurious response and reset:
  - Stimulus: `m_rvalid` pulsed in IDLE → required: no `done`.
  - Stimulus: `rst` asserted during WAIT, then `m_rvalid` after release → required: outputs go to reset values immediately, no `done`, state IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and load/store
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    // fetch requester
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    // load/store requester
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    // pipeline stalls
    output logic              stall_if,
    output logic              stall_mem,
    // memory port
    output logic              m_req,
    output logic              m_we,
    output logic [2:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    logic       owner;       // 0 = fetch, 1 = data
    logic [3:0] starve_cnt;  // consecutive arbitration losses of fetch
    logic       fetch_wins;

    // Data has priority; fetch only wins alone or once it has lost STARVE_MAX times in a row.
    assign fetch_wins = if_req & (~d_req | (starve_cnt == STARVE_LIM));

    // A stage stalls while its request is outstanding and not completing this cycle.
    assign stall_if  = if_req & ~if_done;
    assign stall_mem = d_req & ~d_done;

    // Grant, issue, wait for response and complete; one transaction in flight at a time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            starve_cnt <= 4'd0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_size     <= 3'd0;
            m_addr     <= '0;
            m_wdata    <= '0;
            if_done    <= 1'b0;
            d_done     <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            // completion pulses last exactly the RESP cycle
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req | d_req) begin
                        m_req <= 1'b1;
                        state <= ISSUE;
                        if (fetch_wins) begin
                            owner      <= 1'b0;
                            starve_cnt <= 4'd0;
                            m_we       <= 1'b0;
                            m_size     <= 3'b010;
                            m_addr     <= if_addr;
                            m_wdata    <= '0;
                        end else begin
                            owner   <= 1'b1;
                            m_we    <= d_we;
                            m_size  <= d_size;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            if (if_req && (starve_cnt < STARVE_LIM)) begin
                                starve_cnt <= starve_cnt + 4'd1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    // attributes stay frozen until memory takes the request
                    if (m_ready) begin
                        m_req <= 1'b0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (m_rvalid) begin
                        if (owner) begin
                            d_rdata <= m_rdata;
                            d_done  <= 1'b1;
                        end else begin
                            if_rdata <= m_rdata;
                            if_done  <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          d_req;
    logic          d_we;
    logic [2:0]    d_size;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          stall_if;
    logic          stall_mem;
    logic          m_req;
    logic          m_we;
    logic [2:0]    m_size;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_ready;
    logic          m_rvalid;
    logic [DW-1:0] m_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .m_req(m_req), .m_we(m_we), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: each grant is a record with grant/accept/response cycle stamps.
    int          cyc = 0;
    bit          t_act = 1'b0;
    bit          t_own = 1'b0;
    int          t_g = 0;
    int          t_acc = -1;
    int          t_rsp = -1;
    int          starve = 0;
    logic        e_we = 1'b0;
    logic [2:0]  e_size = 3'd0;
    logic [31:0] e_addr = 32'd0;
    logic [31:0] e_wdata = 32'd0;
    logic [31:0] e_if_rdata = 32'd0;
    logic [31:0] e_d_rdata = 32'd0;
    logic        x_mreq;
    logic        x_ifd;
    logic        x_dd;
    bit          f_win;

    // Every cycle: derive expected outputs from the record, compare, then advance on this cycle's inputs.
    always @(negedge clk) begin
        if (rst) begin
            t_act      = 1'b0;
            starve     = 0;
            e_we       = 1'b0;
            e_size     = 3'd0;
            e_addr     = 32'd0;
            e_wdata    = 32'd0;
            e_if_rdata = 32'd0;
            e_d_rdata  = 32'd0;
        end
        x_mreq = t_act && (cyc > t_g) && (t_acc < 0);
        x_ifd  = t_act && (t_rsp >= 0) && (cyc == t_rsp + 1) && !t_own;
        x_dd   = t_act && (t_rsp >= 0) && (cyc == t_rsp + 1) && t_own;
        chk("m_req", 32'(m_req), 32'(x_mreq));
        chk("m_we", 32'(m_we), 32'(e_we));
        chk("m_size", 32'(m_size), 32'(e_size));
        chk("m_addr", m_addr, e_addr);
        chk("m_wdata", m_wdata, e_wdata);
        chk("if_done", 32'(if_done), 32'(x_ifd));
        chk("d_done", 32'(d_done), 32'(x_dd));
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("d_rdata", d_rdata, e_d_rdata);
        chk("stall_if", 32'(stall_if), 32'(if_req & ~x_ifd));
        chk("stall_mem", 32'(stall_mem), 32'(d_req & ~x_dd));
        if (!rst) begin
            if (t_act) begin
                if (t_rsp >= 0) begin
                    if (cyc == t_rsp + 1) t_act = 1'b0;
                end else if (t_acc >= 0) begin
                    if (cyc > t_acc && m_rvalid) begin
                        t_rsp = cyc;
                        if (t_own) e_d_rdata = m_rdata;
                        else       e_if_rdata = m_rdata;
                    end
                end else if (cyc > t_g && m_ready) begin
                    t_acc = cyc;
                end
            end else if (if_req || d_req) begin
                f_win = if_req && (!d_req || starve == SMAX);
                if (f_win) begin
                    starve  = 0;
                    t_own   = 1'b0;
                    e_we    = 1'b0;
                    e_size  = 3'b010;
                    e_addr  = if_addr;
                    e_wdata = 32'd0;
                end else begin
                    if (if_req && starve < SMAX) starve = starve + 1;
                    t_own   = 1'b1;
                    e_we    = d_we;
                    e_size  = d_size;
                    e_addr  = d_addr;
                    e_wdata = d_wdata;
                end
                t_act = 1'b1;
                t_g   = cyc;
                t_acc = -1;
                t_rsp = -1;
            end
        end
        cyc++;
    end

    int   seq[$];
    int   nd;
    logic if_done_s;
    logic d_done_s;

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_size = 3'd0;
        d_addr = '0; d_wdata = '0; m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        tick(); tick();
        @(negedge clk);
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_m_size", 32'(m_size), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        tick(); rst = 1'b0;

        // single fetch
        tick(); if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        chk("sf_c0_m_req", 32'(m_req), 32'd0);
        chk("sf_c0_stall_if", 32'(stall_if), 32'd1);
        tick(); m_ready = 1'b1;
        @(negedge clk);
        chk("sf_c1_m_req", 32'(m_req), 32'd1);
        chk("sf_c1_m_addr", m_addr, 32'h100);
        chk("sf_c1_m_we", 32'(m_we), 32'd0);
        tick(); m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h00500093;
        @(negedge clk);
        chk("sf_c2_m_req", 32'(m_req), 32'd0);
        chk("sf_c2_stall_if", 32'(stall_if), 32'd1);
        tick(); m_rvalid = 1'b0;
        @(negedge clk);
        chk("sf_c3_if_done", 32'(if_done), 32'd1);
        chk("sf_c3_if_rdata", if_rdata, 32'h00500093);
        chk("sf_c3_stall_if", 32'(stall_if), 32'd0);
        tick(); if_req = 1'b0;
        @(negedge clk);
        chk("sf_c4_if_done", 32'(if_done), 32'd0);

        // simultaneous fetch and store
        tick(); if_req = 1'b1; if_addr = 32'h104;
        d_req = 1'b1; d_we = 1'b1; d_size = 3'd2; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
        tick(); m_ready = 1'b1;
        @(negedge clk);
        chk("sim_c1_m_we", 32'(m_we), 32'd1);
        chk("sim_c1_m_addr", m_addr, 32'h200);
        chk("sim_c1_m_wdata", m_wdata, 32'hDEADBEEF);
        tick(); m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0;
        tick(); m_rvalid = 1'b0;
        @(negedge clk);
        chk("sim_c3_d_done", 32'(d_done), 32'd1);
        chk("sim_c3_stall_if", 32'(stall_if), 32'd1);
        tick(); d_req = 1'b0; d_we = 1'b0;
        tick(); m_ready = 1'b1;
        @(negedge clk);
        chk("sim_c5_m_req", 32'(m_req), 32'd1);
        chk("sim_c5_m_addr", m_addr, 32'h104);
        tick(); m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h00000013;
        tick(); m_rvalid = 1'b0;
        @(negedge clk);
        chk("sim_c7_if_done", 32'(if_done), 32'd1);
        chk("sim_c7_if_rdata", if_rdata, 32'h00000013);
        tick(); if_req = 1'b0;

        // starvation: both held, memory always ready
        tick(); if_req = 1'b1; if_addr = 32'h400;
        d_req = 1'b1; d_we = 1'b0; d_size = 3'd2; d_addr = 32'h500; d_wdata = 32'h0;
        m_ready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h77;
        for (int k = 0; k < 200 && seq.size() < 15; k++) begin
            @(negedge clk);
            if (d_done) seq.push_back(1);
            if (if_done) seq.push_back(0);
        end
        tick(); if_req = 1'b0; d_req = 1'b0; m_ready = 1'b0; m_rvalid = 1'b0;
        chk("starve_count", 32'(seq.size()), 32'd15);
        for (int i = 0; i < seq.size(); i++) begin
            chk($sformatf("starve_seq%0d", i), 32'(seq[i]), (i % 5 == 4) ? 32'd0 : 32'd1);
        end

        // backpressure on a load
        tick(); d_req = 1'b1; d_we = 1'b0; d_size = 3'd0; d_addr = 32'h300; d_wdata = 32'h11111111;
        nd = 0;
        for (int cy = 1; cy <= 11; cy++) begin
            tick();
            m_ready  = (cy == 4);
            m_rvalid = (cy == 9) || (cy == 2);
            m_rdata  = (cy == 9) ? 32'hCAFE0001 : $urandom;
            if (cy == 11) d_req = 1'b0;
            @(negedge clk);
            if (cy <= 4) begin
                chk($sformatf("bp_c%0d_m_req", cy), 32'(m_req), 32'd1);
                chk($sformatf("bp_c%0d_m_addr", cy), m_addr, 32'h300);
            end
            if (d_done) begin
                nd++;
                chk("bp_done_cycle", 32'(cy), 32'd10);
            end
        end
        chk("bp_done_count", 32'(nd), 32'd1);
        chk("bp_d_rdata", d_rdata, 32'hCAFE0001);

        // spurious response while idle
        tick(); m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h5555AAAA;
        for (int k = 0; k < 4; k++) begin
            tick(); m_rvalid = (k == 0);
            @(negedge clk);
            chk("spur_no_done", 32'(if_done | d_done), 32'd0);
        end

        // reset while waiting for a response
        tick(); if_req = 1'b1; if_addr = 32'h600;
        tick(); m_ready = 1'b1;
        tick(); m_ready = 1'b0;
        tick(); rst = 1'b1; if_req = 1'b0;
        #1;
        chk("rw_m_addr", m_addr, 32'h0);
        chk("rw_m_size", 32'(m_size), 32'd0);
        chk("rw_m_req", 32'(m_req), 32'd0);
        tick(); rst = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h12345678;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rw_no_done", 32'(if_done | d_done), 32'd0);
            tick(); m_rvalid = 1'b0;
        end

        // randomized traffic
        if_done_s = 1'b0;
        d_done_s  = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (k % 1000 == 500) begin
                rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
            end else begin
                rst = 1'b0;
                if (if_req ? if_done_s : ($urandom_range(99, 0) < 30)) begin
                    if (!if_req || $urandom_range(99, 0) < 50) begin
                        if_req  = 1'b1;
                        if_addr = $urandom & 32'hFFFFFFFC;
                    end else begin
                        if_req = 1'b0;
                    end
                end
                if (d_req ? d_done_s : ($urandom_range(99, 0) < 30)) begin
                    if (!d_req || $urandom_range(99, 0) < 50) begin
                        d_req   = 1'b1;
                        d_we    = ($urandom_range(1, 0) == 1);
                        d_size  = 3'($urandom_range(7, 0));
                        d_addr  = $urandom;
                        d_wdata = $urandom;
                    end else begin
                        d_req = 1'b0;
                    end
                end
            end
            m_ready  = ($urandom_range(99, 0) < 50);
            m_rvalid = ($urandom_range(99, 0) < 40);
            m_rdata  = $urandom;
            @(negedge clk);
            if_done_s = if_done;
            d_done_s  = d_done;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
